// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state type and window slot helper
// for the 3x3 sliding-window generator.
package conv_pkg;

  localparam int KERNEL = 3;
  localparam int SLOTS  = KERNEL * KERNEL;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  function automatic int slot_lsb(
    input int k,
    input int ch,
    input int dw
  );
    return k * ch * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one-row delay line built as a single-port
// circular RAM; read and write share the same address each beat.
module conv_line_buffer #(
  parameter int DEPTH = 44,
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;

  assign dout = mem_q[ptr_q];

  // advance the shared address on every enabled beat
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // address register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // storage is never cleared; the window logic gates stale data
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster stream to 3x3 x CHANNEL window generator.
// Define CONV_PAD_SAME_EN for zero-padded "same" mode with flush.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 16,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int STRIDE     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Valid_In,
  input  logic [DATA_WIDHT*CHANNEL-1:0]       Data_In,
  output logic                                Valid_Out,
  output logic [SLOTS*DATA_WIDHT*CHANNEL-1:0] Data_Out,
  output logic                                Frame_Done
);

  localparam int PIX = DATA_WIDHT * CHANNEL;
  localparam int CW  = $clog2(IMG_WIDHT);
  localparam int RW  = $clog2(IMG_HEIGHT);
`ifdef CONV_PAD_SAME_EN
  localparam int FW     = $clog2(IMG_WIDHT + 1);
  localparam int LAST_R = ((IMG_HEIGHT - 1) / STRIDE) * STRIDE;
  localparam int LAST_C = ((IMG_WIDHT - 1) / STRIDE) * STRIDE;
`else
  localparam int LAST_R = 2 + ((IMG_HEIGHT - 3) / STRIDE) * STRIDE;
  localparam int LAST_C = 2 + ((IMG_WIDHT - 3) / STRIDE) * STRIDE;
`endif

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             acc, beat, last_px;
  logic [PIX-1:0]   din, lb1_out, lb2_out, slot;
  logic [PIX-1:0]   win_q [SLOTS];
  logic [PIX-1:0]   win_d [SLOTS];
  logic [PIX-1:0]   win_sh [SLOTS];
  logic             vout_q, vout_d;
  logic             fd_q, fd_d;
  logic [SLOTS*PIX-1:0] dout_q, dout_d;
  logic             emit, last_win;
  int               qr, qc;

`ifdef CONV_PAD_SAME_EN
  state_e           state_q, state_d;
  logic [FW-1:0]    fl_q, fl_d;
  int               cr, cc;

  assign acc  = Valid_In && (state_q == RUN);
  assign beat = acc || (state_q == FLUSH);
  assign din  = (state_q == FLUSH) ? '0 : Data_In;

  // run/flush sequencing: W+1 zero beats drain the last rows
  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    unique case (state_q)
      RUN: begin
        if (acc && last_px) state_d = FLUSH;
      end
      FLUSH: begin
        if (fl_q == FW'(IMG_WIDHT)) begin
          state_d = RUN;
          fl_d    = '0;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // fsm state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
    end
  end
`else
  assign acc  = Valid_In;
  assign beat = acc;
  assign din  = Data_In;
`endif

  // raster position of the pixel being accepted
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    last_px = (col_q == CW'(IMG_WIDHT - 1)) &&
              (row_q == RW'(IMG_HEIGHT - 1));
    if (acc) begin
      if (col_q == CW'(IMG_WIDHT - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  conv_line_buffer #(
    .DEPTH (IMG_WIDHT),
    .WIDTH (PIX)
  ) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (beat),
    .din  (din),
    .dout (lb1_out)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDHT),
    .WIDTH (PIX)
  ) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (beat),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // decide whether this beat completes an output window
  always_comb begin
    qr = int'(row_q);
    qc = int'(col_q);
`ifdef CONV_PAD_SAME_EN
    if (state_q == FLUSH) begin
      qr = (fl_q == FW'(IMG_WIDHT)) ? IMG_HEIGHT + 1 : IMG_HEIGHT;
      qc = (fl_q == FW'(IMG_WIDHT)) ? 0 : int'(fl_q);
    end
    cc = (qc == 0) ? IMG_WIDHT - 1 : qc - 1;
    cr = (qc == 0) ? qr - 2 : qr - 1;
    emit = (cr >= 0) && (cr % STRIDE == 0) && (cc % STRIDE == 0);
    last_win = (cr == LAST_R) && (cc == LAST_C);
`else
    emit = (qr >= 2) && (qc >= 2) &&
           ((qr - 2) % STRIDE == 0) && ((qc - 2) % STRIDE == 0);
    last_win = (qr == LAST_R) && (qc == LAST_C);
`endif
  end

  // shift window left; new right column is {2 rows up, 1 up, now}
  always_comb begin
    for (int i = 0; i < KERNEL; i++) begin
      win_sh[KERNEL*i]   = win_q[KERNEL*i+1];
      win_sh[KERNEL*i+1] = win_q[KERNEL*i+2];
    end
    win_sh[2] = lb2_out;
    win_sh[5] = lb1_out;
    win_sh[8] = din;
    for (int k = 0; k < SLOTS; k++) begin
      win_d[k] = beat ? win_sh[k] : win_q[k];
    end
  end

  // assemble the registered output window
  always_comb begin
    vout_d = beat && emit;
    fd_d   = beat && emit && last_win;
    dout_d = dout_q;
    slot   = '0;
    if (beat && emit) begin
      for (int i = 0; i < KERNEL; i++) begin
        for (int j = 0; j < KERNEL; j++) begin
          slot = win_sh[KERNEL*i+j];
`ifdef CONV_PAD_SAME_EN
          if ((i == 0 && cr == 0) ||
              (i == KERNEL - 1 && cr == IMG_HEIGHT - 1) ||
              (j == 0 && cc == 0) ||
              (j == KERNEL - 1 && cc == IMG_WIDHT - 1)) begin
            slot = '0;
          end
`endif
          dout_d[slot_lsb(KERNEL*i+j, CHANNEL, DATA_WIDHT) +: PIX] = slot;
        end
      end
    end
  end

  // counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      vout_q <= 1'b0;
      fd_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vout_q <= vout_d;
      fd_q   <= fd_d;
      dout_q <= dout_d;
    end
  end

  // window storage, gated only through win_d
  always_ff @(posedge clk) begin
    for (int k = 0; k < SLOTS; k++) begin
      win_q[k] <= win_d[k];
    end
  end

  assign Valid_Out  = vout_q;
  assign Data_Out   = dout_q;
  assign Frame_Done = fd_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed table-driven bench for conv_window_gen,
// valid mode by default, padded mode when CONV_PAD_SAME_EN is defined.
`timescale 1ns/1ps
module tb_conv_window_gen;

  localparam int DW = 32;

  typedef struct {
    int                  cyc;
    logic [9*16*DW-1:0]  data;
    bit                  fd;
  } mon_t;

  typedef struct {
    int trig;
    int v[9];
    bit fd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b, rst_c;
  logic v_a, v_b, v_c;
  logic [DW-1:0]      d_a, d_b;
  logic [16*DW-1:0]   d_c;
  logic vo_a, vo_b, vo_c;
  logic fd_a, fd_b, fd_c;
  logic [9*DW-1:0]    do_a, do_b;
  logic [9*16*DW-1:0] do_c;

  conv_window_gen #(
    .DATA_WIDHT(DW), .CHANNEL(1), .IMG_WIDHT(4),
    .IMG_HEIGHT(4), .STRIDE(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .Valid_In(v_a), .Data_In(d_a),
    .Valid_Out(vo_a), .Data_Out(do_a), .Frame_Done(fd_a)
  );

  conv_window_gen #(
    .DATA_WIDHT(DW), .CHANNEL(1), .IMG_WIDHT(6),
    .IMG_HEIGHT(6), .STRIDE(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .Valid_In(v_b), .Data_In(d_b),
    .Valid_Out(vo_b), .Data_Out(do_b), .Frame_Done(fd_b)
  );

  conv_window_gen #(
    .DATA_WIDHT(DW), .CHANNEL(16), .IMG_WIDHT(4),
    .IMG_HEIGHT(4), .STRIDE(1)
  ) dut_c (
    .clk(clk), .rst(rst_c), .Valid_In(v_c), .Data_In(d_c),
    .Valid_Out(vo_c), .Data_Out(do_c), .Frame_Done(fd_c)
  );

  mon_t q_a[$];
  mon_t q_b[$];
  mon_t q_c[$];

  // log every cycle that shows Valid_Out or a Frame_Done pulse
  always @(negedge clk) begin
    mon_t m;
    if (vo_a || fd_a) begin
      m.cyc = cyc; m.data = '0; m.data[9*DW-1:0] = do_a; m.fd = fd_a;
      q_a.push_back(m);
    end
    if (vo_b || fd_b) begin
      m.cyc = cyc; m.data = '0; m.data[9*DW-1:0] = do_b; m.fd = fd_b;
      q_b.push_back(m);
    end
    if (vo_c || fd_c) begin
      m.cyc = cyc; m.data = do_c; m.fd = fd_c;
      q_c.push_back(m);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vec_a[4];
  vec_t vec_b[4];
  vec_t vec_pad[2];
  int acc[64];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_win(input string tag, input mon_t m,
                           input int ecyc, input int ev[9],
                           input int nch, input bit efd);
    chk({tag, ".cyc"}, 512'(m.cyc), 512'(ecyc));
    chk({tag, ".fd"}, 512'(m.fd), 512'(efd));
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < nch; c++) begin
        chk($sformatf("%s.s%0d.c%0d", tag, k, c),
            512'(m.data[(k*nch+c)*DW +: DW]), 512'(ev[k] + c));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    end
  endtask

  task automatic beat_a(input int d, output int a);
    @(negedge clk);
    v_a = 1'b1; d_a = 32'(d); a = cyc + 1;
  endtask

  task automatic beat_b(input int d, output int a);
    @(negedge clk);
    v_b = 1'b1; d_b = 32'(d); a = cyc + 1;
  endtask

  task automatic beat_c(input int p, input int off, output int a);
    @(negedge clk);
    v_c = 1'b1;
    for (int c = 0; c < 16; c++) d_c[c*DW +: DW] = 32'(p*16 + c + off);
    a = cyc + 1;
  endtask

  task automatic check_a_frame(input string tag);
    chk({tag, ".count"}, 512'(q_a.size()), 512'(4));
    for (int n = 0; n < 4 && n < q_a.size(); n++) begin
      check_win($sformatf("%s.w%0d", tag, n), q_a[n],
                acc[vec_a[n].trig], vec_a[n].v, 1, vec_a[n].fd);
    end
    q_a.delete();
  endtask

  function automatic int pad_v(input int r, input int c,
                               input int k, input int off);
    int rr, cc;
    rr = r - 1 + k / 3;
    cc = c - 1 + k % 3;
    if (rr < 0 || rr > 3 || cc < 0 || cc > 3) return 0;
    return rr*4 + cc + off;
  endfunction

  initial begin
    int ev[9];
    int f, p, w;

    vec_a[0].trig = 10; vec_a[0].v = '{0,1,2,4,5,6,8,9,10};   vec_a[0].fd = 0;
    vec_a[1].trig = 11; vec_a[1].v = '{1,2,3,5,6,7,9,10,11};  vec_a[1].fd = 0;
    vec_a[2].trig = 14; vec_a[2].v = '{4,5,6,8,9,10,12,13,14}; vec_a[2].fd = 0;
    vec_a[3].trig = 15; vec_a[3].v = '{5,6,7,9,10,11,13,14,15}; vec_a[3].fd = 1;

    vec_b[0].trig = 14; vec_b[0].v = '{0,1,2,6,7,8,12,13,14};     vec_b[0].fd = 0;
    vec_b[1].trig = 16; vec_b[1].v = '{2,3,4,8,9,10,14,15,16};    vec_b[1].fd = 0;
    vec_b[2].trig = 26; vec_b[2].v = '{12,13,14,18,19,20,24,25,26}; vec_b[2].fd = 0;
    vec_b[3].trig = 28; vec_b[3].v = '{14,15,16,20,21,22,26,27,28}; vec_b[3].fd = 1;

    vec_pad[0].trig = 0;  vec_pad[0].v = '{0,0,0,0,0,1,0,4,5};       vec_pad[0].fd = 0;
    vec_pad[1].trig = 15; vec_pad[1].v = '{10,11,0,14,15,0,0,0,0};   vec_pad[1].fd = 1;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    d_a = '0; d_b = '0; d_c = '0;
    repeat (3) @(negedge clk);

    chk("rst.vo_a", 512'(vo_a), 512'(0));
    chk("rst.fd_a", 512'(fd_a), 512'(0));
    chk("rst.do_a", 512'(do_a), 512'(0));
    chk("rst.vo_b", 512'(vo_b), 512'(0));
    chk("rst.fd_b", 512'(fd_b), 512'(0));
    chk("rst.do_b", 512'(do_b), 512'(0));
    chk("rst.vo_c", 512'(vo_c), 512'(0));
    chk("rst.fd_c", 512'(fd_c), 512'(0));
    chk("rst.do_c_zero", 512'(do_c == '0), 512'(1));
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    q_a.delete(); q_b.delete(); q_c.delete();

`ifdef CONV_PAD_SAME_EN
    for (int fr = 0; fr < 2; fr++) begin
      for (int px = 0; px < 16; px++) beat_a(fr*100 + px, acc[fr*16 + px]);
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        v_a = (fr == 0 && s == 1);
        d_a = 32'd99;
      end
    end
    idle(4);
    chk("pad.count", 512'(q_a.size()), 512'(32));
    for (int n = 0; n < 32 && n < q_a.size(); n++) begin
      f = n / 16;
      p = n % 16;
      if (f == 0 && p == 0) ev = vec_pad[0].v;
      else if (f == 0 && p == 15) ev = vec_pad[1].v;
      else for (int k = 0; k < 9; k++) ev[k] = pad_v(p / 4, p % 4, k, f*100);
      check_win($sformatf("pad.f%0d.p%0d", f, p), q_a[n],
                acc[f*16] + p + 5, ev, 1, p == 15);
    end
    q_a.delete();
`else
    for (int px = 0; px < 16; px++) beat_a(px, acc[px]);
    idle(3);
    check_a_frame("cont");

    for (int px = 0; px < 16; px++) begin
      beat_a(px, acc[px]);
      idle(1);
    end
    idle(3);
    check_a_frame("gap");

    for (int px = 0; px < 7; px++) beat_a(px + 40, acc[px]);
    idle(1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort.none", 512'(q_a.size()), 512'(0));
    q_a.delete();
    for (int px = 0; px < 16; px++) beat_a(px, acc[px]);
    idle(3);
    check_a_frame("abort");

    for (int px = 0; px < 36; px++) beat_b(px, acc[px]);
    idle(3);
    chk("s2.count", 512'(q_b.size()), 512'(4));
    for (int n = 0; n < 4 && n < q_b.size(); n++) begin
      check_win($sformatf("s2.w%0d", n), q_b[n],
                acc[vec_b[n].trig], vec_b[n].v, 1, vec_b[n].fd);
    end
    q_b.delete();

    for (int fr = 0; fr < 2; fr++) begin
      for (int px = 0; px < 16; px++) beat_c(px, fr*4096, acc[fr*16 + px]);
    end
    idle(3);
    chk("ch16.count", 512'(q_c.size()), 512'(8));
    for (int n = 0; n < 8 && n < q_c.size(); n++) begin
      f = n / 4;
      w = n % 4;
      for (int k = 0; k < 9; k++) ev[k] = vec_a[w].v[k]*16 + f*4096;
      check_win($sformatf("ch16.f%0d.w%0d", f, w), q_c[n],
                acc[f*16 + vec_a[w].trig], ev, 16, vec_a[w].fd);
    end
    q_c.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised 3x3 sliding-window generator for the convolution layers. Accepts a raster-order feature-map stream with all input channels in parallel per beat and emits one full 3x3 x CHANNEL window per output position. It replaces the fixed-size per-layer window logic, so every layer instantiates one generator configured by image size, channel count and stride. Sits between the previous layer's output stream and the MAC array.

## Interface
- DATA_WIDHT, 32, bits per channel sample
- CHANNEL, 16, channels carried in parallel per beat
- IMG_WIDHT, 44, feature-map width in pixels (>= 3)
- IMG_HEIGHT, 44, feature-map height in pixels (>= 3)
- STRIDE, 1, window stride, 1 or 2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- Valid_In  in  1  Data_In carries a pixel this cycle
- Data_In  in  DATA_WIDHT*CHANNEL  one pixel; channel c at bits [c*DATA_WIDHT +: DATA_WIDHT]
- Valid_Out  out  1  Data_Out carries a window this cycle
- Data_Out  out  9*DATA_WIDHT*CHANNEL  window; slot k = 3*i+j (i row 0=top, j col 0=left) at [k*CHANNEL*DATA_WIDHT +: CHANNEL*DATA_WIDHT], channel order as Data_In
- Frame_Done  out  1  one-cycle pulse with the last window of a frame

## Operation
- Column counter col (0..IMG_WIDHT-1) and row counter row (0..IMG_HEIGHT-1) track the pixel accepted on each Valid_In beat; col wraps to 0 and row increments; after (IMG_HEIGHT-1, IMG_WIDHT-1) both wrap to 0 (next frame follows back-to-back).
- Two line buffers of IMG_WIDHT pixels hold the previous two rows; a 3x3 register array shifts left one column per accepted beat, new column = {line2 out, line1 out, Data_In}.
- No backpressure; Valid_In gaps of any length freeze counters, buffers and window.
- Valid (unpadded) mode: window centred at (row-1, col-1) is emitted when the accepted pixel has row >= 2, col >= 2, (row-2) % STRIDE == 0, (col-2) % STRIDE == 0. Outputs per frame: ((IMG_HEIGHT-3)/STRIDE+1) * ((IMG_WIDHT-3)/STRIDE+1).
- Frame_Done asserts with the Valid_Out of the last window of the frame.
- Arithmetic: none on data; samples pass through bit-exact. Counters sized $clog2 of their range.

## Timing
- Reset values: Valid_Out 0, Data_Out 0, Frame_Done 0, col/row 0, state RUN. Line-buffer contents not cleared (outputs gated by counters).
- Latency: Valid_Out/Data_Out registered, 1 cycle after the triggering accepted beat.
- rst mid-frame: frame abandoned, no further outputs for it; next accepted pixel is (0,0).
- Window ignores wrap artefacts: outputs only generated for col >= 2, so stale columns from the previous row never appear.

## Configuration
- CONV_PAD_SAME_EN defined: zero-padded "same" mode. Output window centred at every (r, c) with r % STRIDE == 0, c % STRIDE == 0; out-of-image neighbours forced to zero by position muxing. Window for pixel index p emitted on the beat accepting index p+IMG_WIDHT+1. FSM RUN -> FLUSH after last pixel; FLUSH injects IMG_WIDHT+1 internal zero beats, one per cycle, then -> RUN. Valid_In during FLUSH is ignored (beat dropped). Frame_Done with last flushed window.
- Not defined: valid mode only; no FLUSH state, no padding muxes.

## Structure
- Package conv_pkg: KERNEL = 3, state enum {RUN, FLUSH}, slot-offset function slot_lsb(k, CHANNEL, DATA_WIDHT).
- Sub-module conv_line_buffer: single-port shift RAM of depth IMG_WIDHT, width DATA_WIDHT*CHANNEL, enable-gated; two instances chained.

## Test plan
- W=H=4, CHANNEL=1, pixel value = raster index, continuous Valid_In -> first Valid_Out 1 cycle after pixel 10 with slots {0,1,2,4,5,6,8,9,10}; 4 windows total; Frame_Done with window {5,6,7,9,10,11,13,14,15}.
- W=H=6, STRIDE=2 -> 2x2 = 4 windows, centres (1,1),(1,3),(3,1),(3,3); first slots {0,1,2,6,7,8,12,13,14}.
- Same as first, Valid_In high every other cycle -> identical window sequence, each 1 cycle after its trigger beat.
- rst asserted after 7 pixels, then full frame -> output identical to clean-frame run, no window from aborted frame.
- CONV_PAD_SAME_EN, W=H=4 -> first window after pixel 5: {0,0,0,0,0,1,0,4,5}; 16 windows; last {10,11,0,14,15,0,0,0,0} on 5th FLUSH cycle with Frame_Done; Valid_In pulse during FLUSH dropped.
- CHANNEL=16, two frames back-to-back -> channel c of each slot equals input channel c; second frame's windows match first with no cross-frame mixing.
